// File: rtl/multi_buffer_ram_pkg.sv
// multi_buffer_pkg: shared types for the multi-buffer sample store.
//   buf_state_e : lifecycle of one buffer (FREE -> FILLING -> READY -> READING -> FREE)
//   wr_state_e  : writer is either filling a buffer or stalled waiting for a FREE one
//   OVF_*       : overflow policy selector values for the OVF_MODE parameter
package multi_buffer_pkg;

   typedef enum logic [1:0] {
      BUF_FREE,
      BUF_FILLING,
      BUF_READY,
      BUF_READING
   } buf_state_e;

   typedef enum logic {
      WR_FILL,
      WR_STALL
   } wr_state_e;

   localparam int OVF_BACKPRESSURE = 0;
   localparam int OVF_DROP         = 1;

endpackage

// File: rtl/multi_buffer_ram_dpram.sv
// generic_dpram: simple dual-port RAM, one write port and one registered read port.
//   clk_i                      : clock
//   wr_en_i/wr_addr_i/wr_data_i: write port, written on the rising edge
//   rd_en_i/rd_addr_i          : read request, data appears on rd_data_o one cycle later
//   rd_data_o                  : registered read data (holds when no read is requested)
module generic_dpram #(
   parameter  int DATA_WIDTH = 32,
   parameter  int DEPTH      = 16,
   localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk_i,
   input  logic                  wr_en_i,
   input  logic [AW-1:0]         wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   input  logic [AW-1:0]         rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
      if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/multi_buffer_ram.sv
// multi_buffer_ram: N-buffer multi-channel sample store with claim/release reader.
//   clk_i, rst_i                  : clock, asynchronous active-high reset
//   in_valid_i/in_data_i/in_ready_o: one multi-channel frame per accepted beat
//   buf_ready_pulse_o/_id_o       : one-cycle notice that a buffer completed
//   rd_avail_o                    : at least one completed buffer is queued
//   rd_claim_i/rd_release_i       : take the oldest queued buffer / give it back
//   rd_active_o/rd_buf_id_o       : claimed buffer status and id
//   rd_en_i/rd_addr_i/rd_ch_i     : read one channel of one frame of the claimed buffer
//   rd_data_o/rd_data_valid_o     : read result, one cycle after the request
//   ovf_count_o/ovf_sticky_o      : dropped-frame count (saturating) and overflow flag
module multi_buffer_ram
   import multi_buffer_pkg::*;
#(
   parameter  int DATA_WIDTH      = 16,
   parameter  int NUM_CH          = 4,
   parameter  int SAMPLES_PER_BUF = 256,
   parameter  int NUM_BUFS        = 3,
   parameter  int OVF_MODE        = 0,
   localparam int AW              = $clog2(SAMPLES_PER_BUF),
   localparam int CW              = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int BW              = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         in_valid_i,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_data_i,
   output logic                         in_ready_o,
   output logic                         buf_ready_pulse_o,
   output logic [BW-1:0]                buf_ready_id_o,
   output logic                         rd_avail_o,
   input  logic                         rd_claim_i,
   input  logic                         rd_release_i,
   output logic                         rd_active_o,
   output logic [BW-1:0]                rd_buf_id_o,
   input  logic                         rd_en_i,
   input  logic [AW-1:0]                rd_addr_i,
   input  logic [CW-1:0]                rd_ch_i,
   output logic [DATA_WIDTH-1:0]        rd_data_o,
   output logic                         rd_data_valid_o,
   output logic [15:0]                  ovf_count_o,
   output logic                         ovf_sticky_o
);

   localparam int FW    = NUM_CH*DATA_WIDTH;
   localparam int DEPTH = NUM_BUFS*SAMPLES_PER_BUF;
   localparam int RAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NW    = $clog2(NUM_BUFS+1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(SAMPLES_PER_BUF-1);
   localparam logic [BW-1:0] LAST_SLOT = BW'(NUM_BUFS-1);

   // Ready FIFO depth is NUM_BUFS, which need not be a power of two.
   function automatic logic [BW-1:0] next_slot(input logic [BW-1:0] p);
      return (p == LAST_SLOT) ? '0 : p + 1'b1;
   endfunction

   buf_state_e        buf_state_q [NUM_BUFS];
   buf_state_e        buf_state_d [NUM_BUFS];
   logic [BW-1:0]     fifo_q [NUM_BUFS];
   logic [BW-1:0]     fifo_d [NUM_BUFS];
   logic [BW-1:0]     head_q, head_d, tail_q, tail_d;
   logic [NW-1:0]     cnt_q, cnt_d;
   wr_state_e         wr_state_q, wr_state_d;
   logic [BW-1:0]     fill_id_q, fill_id_d;
   logic [AW-1:0]     wr_addr_q, wr_addr_d;
   logic              rd_active_q, rd_active_d;
   logic [BW-1:0]     rd_buf_id_q, rd_buf_id_d;
   logic              pulse_q, pulse_d;
   logic [BW-1:0]     pulse_id_q, pulse_id_d;
   logic [15:0]       ovf_count_q, ovf_count_d;
   logic              ovf_sticky_q, ovf_sticky_d;
   logic              rd_vld_q, rd_vld_d;
   logic [CW-1:0]     rd_ch_q, rd_ch_d;

   logic              wr_fire, drop, rel, clm, rd_fire, push, pop, free_any;
   logic [BW-1:0]     free_id;
   logic [FW-1:0]     ram_rdata;

   assign in_ready_o = (wr_state_q == WR_FILL) || (OVF_MODE == OVF_DROP);
   assign wr_fire    = in_valid_i && (wr_state_q == WR_FILL);
   assign drop       = in_valid_i && (wr_state_q == WR_STALL) && (OVF_MODE == OVF_DROP);
   assign rel        = rd_release_i && rd_active_q;
   // Claim is only possible while idle, so a same-edge release always wins.
   assign clm        = rd_claim_i && (cnt_q != '0) && !rd_active_q;
   assign rd_fire    = rd_en_i && rd_active_q;

   always_comb begin
      buf_state_d  = buf_state_q;
      fifo_d       = fifo_q;
      head_d       = head_q;
      tail_d       = tail_q;
      fill_id_d    = fill_id_q;
      wr_addr_d    = wr_addr_q;
      wr_state_d   = wr_state_q;
      rd_active_d  = rd_active_q;
      rd_buf_id_d  = rd_buf_id_q;
      pulse_d      = 1'b0;
      pulse_id_d   = pulse_id_q;
      ovf_count_d  = ovf_count_q;
      ovf_sticky_d = ovf_sticky_q;
      rd_vld_d     = rd_fire;
      rd_ch_d      = rd_fire ? rd_ch_i : rd_ch_q;
      push         = 1'b0;
      pop          = 1'b0;
      free_any     = 1'b0;
      free_id      = '0;

      if (rel) begin
         buf_state_d[rd_buf_id_q] = BUF_FREE;
         rd_active_d              = 1'b0;
      end else if (clm) begin
         buf_state_d[fifo_q[head_q]] = BUF_READING;
         rd_active_d                 = 1'b1;
         rd_buf_id_d                 = fifo_q[head_q];
         head_d                      = next_slot(head_q);
         pop                         = 1'b1;
      end

      // Lowest-index FREE buffer; the one being released this edge qualifies.
      for (int i = NUM_BUFS-1; i >= 0; i--) begin
         if (buf_state_q[i] == BUF_FREE || (rel && rd_buf_id_q == BW'(i))) begin
            free_any = 1'b1;
            free_id  = BW'(i);
         end
      end

      if (wr_state_q == WR_FILL) begin
         if (wr_fire) begin
            if (wr_addr_q == LAST_ADDR) begin
               wr_addr_d              = '0;
               buf_state_d[fill_id_q] = BUF_READY;
               fifo_d[tail_q]         = fill_id_q;
               tail_d                 = next_slot(tail_q);
               push                   = 1'b1;
               pulse_d                = 1'b1;
               pulse_id_d             = fill_id_q;
               if (free_any) begin
                  fill_id_d            = free_id;
                  buf_state_d[free_id] = BUF_FILLING;
               end else begin
                  wr_state_d   = WR_STALL;
                  ovf_sticky_d = 1'b1;
               end
            end else begin
               wr_addr_d = wr_addr_q + 1'b1;
            end
         end
      end else if (rel) begin
         // While stalled, the only way a buffer frees up is a release.
         wr_state_d               = WR_FILL;
         fill_id_d                = rd_buf_id_q;
         buf_state_d[rd_buf_id_q] = BUF_FILLING;
      end

      if (drop && ovf_count_q != 16'hFFFF) ovf_count_d = ovf_count_q + 16'd1;

      cnt_d = cnt_q + NW'(push) - NW'(pop);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_BUFS; i++) buf_state_q[i] <= (i == 0) ? BUF_FILLING : BUF_FREE;
         head_q       <= '0;
         tail_q       <= '0;
         cnt_q        <= '0;
         wr_state_q   <= WR_FILL;
         fill_id_q    <= '0;
         wr_addr_q    <= '0;
         rd_active_q  <= 1'b0;
         rd_buf_id_q  <= '0;
         pulse_q      <= 1'b0;
         pulse_id_q   <= '0;
         ovf_count_q  <= '0;
         ovf_sticky_q <= 1'b0;
         rd_vld_q     <= 1'b0;
      end else begin
         buf_state_q  <= buf_state_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         cnt_q        <= cnt_d;
         wr_state_q   <= wr_state_d;
         fill_id_q    <= fill_id_d;
         wr_addr_q    <= wr_addr_d;
         rd_active_q  <= rd_active_d;
         rd_buf_id_q  <= rd_buf_id_d;
         pulse_q      <= pulse_d;
         pulse_id_q   <= pulse_id_d;
         ovf_count_q  <= ovf_count_d;
         ovf_sticky_q <= ovf_sticky_d;
         rd_vld_q     <= rd_vld_d;
      end
   end

   // FIFO slots and the registered channel select carry data only.
   always_ff @(posedge clk_i) begin
      fifo_q  <= fifo_d;
      rd_ch_q <= rd_ch_d;
   end

   generic_dpram #(
      .DATA_WIDTH(FW),
      .DEPTH     (DEPTH)
   ) u_ram (
      .clk_i    (clk_i),
      .wr_en_i  (wr_fire),
      .wr_addr_i(RAW'(fill_id_q) * RAW'(SAMPLES_PER_BUF) + RAW'(wr_addr_q)),
      .wr_data_i(in_data_i),
      .rd_en_i  (rd_fire),
      .rd_addr_i(RAW'(rd_buf_id_q) * RAW'(SAMPLES_PER_BUF) + RAW'(rd_addr_i)),
      .rd_data_o(ram_rdata)
   );

   // Gated by the valid flag so the output reads 0 out of reset and between reads.
   always_comb begin
      rd_data_o = '0;
      if (rd_vld_q && int'(rd_ch_q) < NUM_CH)
         rd_data_o = ram_rdata[int'(rd_ch_q)*DATA_WIDTH +: DATA_WIDTH];
   end

   assign buf_ready_pulse_o = pulse_q;
   assign buf_ready_id_o    = pulse_id_q;
   assign rd_avail_o        = (cnt_q != '0);
   assign rd_active_o       = rd_active_q;
   assign rd_buf_id_o       = rd_buf_id_q;
   assign rd_data_valid_o   = rd_vld_q;
   assign ovf_count_o       = ovf_count_q;
   assign ovf_sticky_o      = ovf_sticky_q;

endmodule

// File: doc/multi_buffer_ram.md
# multi_buffer_ram

Parametrised N-buffer, multi-channel sample store with an explicit claim/release reader handshake. It sits between the multi-channel sampler and the downstream block processor (FFT / DMA). Full buffers are handed out oldest-first. Overflow behaviour is selectable: either back-pressure the sampler or drop and count.

## Interface
Parameters:
- DATA_WIDTH, 16, bits per channel sample
- NUM_CH, 4, channels per input frame (one frame per write beat)
- SAMPLES_PER_BUF, 256, frames per buffer
- NUM_BUFS, 3, buffer count, ≥2, need not be a power of two
- OVF_MODE, 0, 0 = back-pressure (in_ready_o low), 1 = drop and count
- Derived:
  - AW = $clog2(SAMPLES_PER_BUF)
  - CW = $clog2(NUM_CH) (min 1)
  - BW = $clog2(NUM_BUFS) (min 1)

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  asynchronous, active-high reset
- in_valid_i  in  1  frame valid
- in_data_i  in  NUM_CH*DATA_WIDTH  frame; channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- in_ready_o  out  1  frame accepted when in_valid_i & in_ready_o
- buf_ready_pulse_o  out  1  1-cycle pulse, buffer completed
- buf_ready_id_o  out  BW  id of completed buffer, valid with the pulse
- rd_avail_o  out  1  at least one READY buffer is queued
- rd_claim_i  in  1  claim the oldest READY buffer
- rd_release_i  in  1  release the claimed buffer
- rd_active_o  out  1  a buffer is claimed
- rd_buf_id_o  out  BW  claimed buffer id
- rd_en_i  in  1  read request
- rd_addr_i  in  AW  frame index
- rd_ch_i  in  CW  channel select
- rd_data_o  out  DATA_WIDTH  read data
- rd_data_valid_o  out  1  rd_data_o valid
- ovf_count_o  out  16  dropped frames, saturating at 0xFFFF
- ovf_sticky_o  out  1  set on the first drop or stall, cleared only by reset

## Operation
- Each buffer holds one state: FREE, FILLING, READY or READING. At most one buffer is FILLING and at most one is READING.
- Reset state:
  - Buffer 0 is FILLING; all others are FREE.
  - Write address 0, ready queue empty.
  - All outputs 0, except in_ready_o = 1.
- Write path:
  - Each accepted beat writes the whole frame to {fill_id, wr_addr}.
  - wr_addr increments by one per beat and wraps from SAMPLES_PER_BUF-1 to 0.
- Fill completion (accepted beat at wr_addr = SAMPLES_PER_BUF-1):
  - The FILLING buffer becomes READY and its id is pushed to the ready FIFO (depth NUM_BUFS).
  - The lowest-index FREE buffer becomes FILLING. A buffer being released on the same edge counts as FREE.
  - If no buffer is FREE, the writer enters STALL:
    - OVF_MODE = 0: in_ready_o = 0.
    - OVF_MODE = 1: in_ready_o = 1; accepted beats are discarded and ovf_count_o increments.
  - The writer leaves STALL on the edge where any buffer becomes FREE. The new buffer starts at wr_addr 0.
  - ovf_sticky_o is set on entry to STALL.
- Claim:
  - Honoured only when rd_avail_o = 1 and rd_active_o = 0; otherwise ignored.
  - The FIFO head moves READY→READING, rd_active_o = 1 and rd_buf_id_o = that head.
- Release:
  - Honoured only when rd_active_o = 1.
  - The buffer moves READING→FREE and rd_active_o drops.
  - If claim and release arrive on the same edge, only the release is honoured.
- Reads:
  - A read is honoured only while rd_active_o = 1.
  - It returns channel rd_ch_i of frame rd_addr_i from rd_buf_id_o.
  - rd_ch_i ≥ NUM_CH returns 0.
- Memory: one RAM of NUM_BUFS*SAMPLES_PER_BUF words, each NUM_CH*DATA_WIDTH wide. Address = buf_id*SAMPLES_PER_BUF + frame.

## Timing
- Fill completion: buf_ready_pulse_o, buf_ready_id_o and the rd_avail_o rise are all registered, one cycle after the final write edge.
- No dead cycle at a buffer swap when a FREE buffer exists: a beat on the next cycle is written to the new buffer.
- Claim and release take effect at the sampling edge; rd_active_o and rd_buf_id_o update on that edge.
- Read latency is exactly 1 cycle:
  - rd_data_valid_o = registered (rd_en_i & rd_active_o).
  - The channel select is registered alongside the request.
- A read issued in the cycle of a release still completes.
- in_ready_o is combinational from registered state only; it never depends on in_valid_i.
- Asynchronous reset mid-operation aborts everything: queue, counters and states return to reset values, and any in-flight rd_data_valid_o is cleared.

## Structure
- multi_buffer_pkg holds:
  - buf_state_e {BUF_FREE, BUF_FILLING, BUF_READY, BUF_READING}
  - writer state enum {WR_FILL, WR_STALL}
  - OVF_BACKPRESSURE = 0, OVF_DROP = 1
- One sub-module: generic_dpram. It is instantiated once with DATA_WIDTH = NUM_CH*DATA_WIDTH and DEPTH = NUM_BUFS*SAMPLES_PER_BUF.
- Ready FIFO, state array, channel mux and overflow counter are implemented inline.

## Test plan
- **Basic fill and read.** Parameters NUM_BUFS=3, SAMPLES_PER_BUF=8, NUM_CH=4. Stream 8 frames with value {ch,idx}.
  - Pulse one cycle after beat 7, with buf_ready_id_o = 0.
  - Claim, then read frames 0–7 on channel 2: data = {2,idx} with 1-cycle latency.
- **Ordering.** Fill buffers 0 and 1 with no claim.
  - rd_avail_o stays 1.
  - First claim gives id 0; after its release, the next claim gives id 1.
- **Back-pressure (OVF_MODE=0).** Stream continuously with no claims.
  - After 24 beats in_ready_o = 0 and ovf_sticky_o = 1.
  - After claim + release of id 0, in_ready_o returns to 1 on the next cycle and writes go to buffer 0.
- **Drop (OVF_MODE=1).** Same stimulus, plus 5 extra beats.
  - ovf_count_o = 5 and no buffer contents change.
  - After a release, writing resumes at frame 0.
- **Simultaneous events.** Complete a fill with no FREE buffer in the same cycle as rd_release_i.
  - The writer takes the released buffer with no STALL and ovf_sticky_o stays 0.
  - Claim together with release: only the release is honoured.
- **Reset mid-stream.** Assert rst_i during a READING phase with a read in flight.
  - All outputs return to reset values immediately and rd_data_valid_o = 0.
  - After deassertion, writes go to buffer 0 at frame 0.
